// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter: FSM state encoding,
// ALU opcodes and the grant-id decode helper.
package alu_arbiter_pkg;

  localparam int OP_W   = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_SLL = 5'd2;
  localparam logic [4:0] ALU_LT  = 5'd3;
  localparam logic [4:0] ALU_LTU = 5'd4;
  localparam logic [4:0] ALU_XOR = 5'd5;
  localparam logic [4:0] ALU_SRL = 5'd6;
  localparam logic [4:0] ALU_SRA = 5'd7;
  localparam logic [4:0] ALU_OR  = 5'd8;
  localparam logic [4:0] ALU_AND = 5'd9;

  // Decode a grant index (up to 8 requesters) into a one-hot vector.
  function automatic logic [7:0] id_onehot(input logic [2:0] id);
    id_onehot = 8'd1 << id;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid request strictly after ptr,
// wrapping around, so the previous winner has lowest priority.
module alu_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic hit_s;

  // Scan candidates in priority order ptr+1, ptr+2, ... with wrap.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    hit_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        hit_s    = (((int'(ptr) + 1 + k) % NUM_REQ) == i) && req[i] && !any;
        grant[i] = grant[i] | hit_s;
        idx      = hit_s ? ID_W'(i) : idx;
        any      = any | hit_s;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external combinational ALU between NUM_REQ
// requesters, with per-requester valid/ready request and response channels.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [5*NUM_REQ-1:0]    req_op,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [31:0]             rsp_result,
  output logic [4:0]              alu_operation,
  output logic [31:0]             alu_operand_1,
  output logic [31:0]             alu_operand_2,
  input  logic [31:0]             alu_result,
  output logic                    busy
);

  arb_state_e         state_r;
  logic [ID_W-1:0]    id_r;
  logic [ID_W-1:0]    ptr_r;
  logic [NUM_REQ-1:0] rsp_valid_r;
  logic [31:0]        rsp_result_r;
  logic [4:0]         op_r;
  logic [31:0]        a_r;
  logic [31:0]        b_r;

  logic [NUM_REQ-1:0] pick_grant_s;
  logic [ID_W-1:0]    pick_idx_s;
  logic               pick_any_s;
  logic               rsp_done_s;
  logic               issue_s;
  logic [4:0]         sel_op_s;
  logic [31:0]        sel_a_s;
  logic [31:0]        sel_b_s;

  alu_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  // Winner operand mux and grant qualification; rsp_valid_r is one-hot on the
  // owner, so masking rsp_ready with it ignores non-owning requesters.
  always_comb begin
    sel_op_s = '0;
    sel_a_s  = '0;
    sel_b_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_op_s = sel_op_s | (req_op[5*i +: 5]  & {5{pick_grant_s[i]}});
      sel_a_s  = sel_a_s  | (req_a[32*i +: 32] & {32{pick_grant_s[i]}});
      sel_b_s  = sel_b_s  | (req_b[32*i +: 32] & {32{pick_grant_s[i]}});
    end
    rsp_done_s = (state_r == ARB_RESP) && (|(rsp_valid_r & rsp_ready));
    issue_s    = pick_any_s && ((state_r == ARB_IDLE) || rsp_done_s);
    req_ready  = issue_s ? pick_grant_s : '0;
  end

  // Control FSM plus operand, result and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ARB_IDLE;
      id_r         <= '0;
      ptr_r        <= ID_W'(NUM_REQ - 1);
      rsp_valid_r  <= '0;
      rsp_result_r <= 32'd0;
      op_r         <= 5'd0;
      a_r          <= 32'd0;
      b_r          <= 32'd0;
    end else begin
      if (issue_s) begin
        op_r  <= sel_op_s;
        a_r   <= sel_a_s;
        b_r   <= sel_b_s;
        id_r  <= pick_idx_s;
        ptr_r <= pick_idx_s;
      end else begin
        ptr_r <= ptr_r;
      end
      case (state_r)
        ARB_IDLE: begin
          state_r <= issue_s ? ARB_EXEC : ARB_IDLE;
        end
        ARB_EXEC: begin
          rsp_result_r <= alu_result;
          rsp_valid_r  <= NUM_REQ'(id_onehot(3'(id_r)));
          state_r      <= ARB_RESP;
        end
        ARB_RESP: begin
          if (rsp_done_s) begin
            rsp_valid_r <= '0;
            state_r     <= issue_s ? ARB_EXEC : ARB_IDLE;
          end else begin
            state_r <= ARB_RESP;
          end
        end
        default: begin
          rsp_valid_r <= '0;
          state_r     <= ARB_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid     = rsp_valid_r;
  assign rsp_result    = rsp_result_r;
  assign alu_operation = op_r;
  assign alu_operand_1 = a_r;
  assign alu_operand_2 = b_r;
  assign busy          = (state_r != ARB_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and a response
// scoreboard filled at issue time and drained on response handshakes.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [5*N-1:0]  req_op;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [31:0]     rsp_result;
  logic [4:0]      alu_operation;
  logic [31:0]     alu_operand_1;
  logic [31:0]     alu_operand_2;
  logic [31:0]     alu_result;
  logic            busy;

  typedef struct {
    logic [1:0]  oh;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   grants, last_cyc, turn;
  int   cnt [2];
  logic [1:0] fired;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .ID_W(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .alu_operation (alu_operation),
    .alu_operand_1 (alu_operand_1),
    .alu_operand_2 (alu_operand_2),
    .alu_result    (alu_result),
    .busy          (busy)
  );

  // External ALU
  always_comb begin
    case (alu_operation)
      ALU_ADD: alu_result = alu_operand_1 + alu_operand_2;
      ALU_SUB: alu_result = alu_operand_1 - alu_operand_2;
      ALU_SLL: alu_result = alu_operand_1 << alu_operand_2[4:0];
      ALU_LT:  alu_result = {31'd0, $signed(alu_operand_1) < $signed(alu_operand_2)};
      ALU_LTU: alu_result = {31'd0, alu_operand_1 < alu_operand_2};
      ALU_XOR: alu_result = alu_operand_1 ^ alu_operand_2;
      ALU_SRL: alu_result = alu_operand_1 >> alu_operand_2[4:0];
      ALU_SRA: alu_result = $signed(alu_operand_1) >>> alu_operand_2[4:0];
      ALU_OR:  alu_result = alu_operand_1 | alu_operand_2;
      ALU_AND: alu_result = alu_operand_1 & alu_operand_2;
      default: alu_result = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] oh, input logic [31:0] res);
    exp_t e;
    e.oh  = oh;
    e.res = res;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[5*i +: 5]  = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_valid[i]      = 1'b1;
  endtask

  // Contention workload: requester 0 SUB then ADDs, requester 1 SLL then XORs.
  task automatic load_op(input int i, input int k);
    if (i == 0) begin
      if (k == 0) set_req(0, ALU_SUB, 32'd10, 32'd3);
      else        set_req(0, ALU_ADD, 32'(100 + k), 32'(3 * k));
    end else begin
      if (k == 0) set_req(1, ALU_SLL, 32'd1, 32'd4);
      else        set_req(1, ALU_XOR, 32'hA5A5_0000 + 32'(k), 32'(k) << 8);
    end
  endtask

  function automatic logic [31:0] exp_res(input int i, input int k);
    if (i == 0) return (k == 0) ? 32'd7 : 32'(100 + 4 * k);
    else        return (k == 0) ? 32'd16 : (32'hA5A5_0000 | 32'(k) | (32'(k) << 8));
  endfunction

  // One isolated operation from requester i, response taken on the first RESP cycle.
  task automatic do_op(input string tag, input int i, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    logic [1:0] oh;
    oh = 2'b01 << i;
    set_req(i, op, a, b);
    push_exp(oh, exp);
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(oh));
    tick();
    req_valid[i] = 1'b0;
    tick();
    chk({tag, "_valid"}, 32'(rsp_valid), 32'(oh));
    chk({tag, "_result"}, rsp_result, exp);
    rsp_ready[i] = 1'b1;
    tick();
    rsp_ready = '0;
    #1;
  endtask

  // Scoreboard drain on every response handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (|(rsp_valid & rsp_ready))) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", 32'(rsp_valid), 32'(mon_e.oh));
        chk("rsp_result", rsp_result, mon_e.res);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_op", 32'(alu_operation), 32'd0);
    chk("rst_alu_a", alu_operand_1, 32'd0);
    rst_n = 1'b1;

    // Single request with one cycle of response backpressure
    tick();
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    push_exp(2'b01, 32'd12);
    #1;
    chk("t1_ready", 32'(req_ready), 32'd1);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    tick();
    req_valid = '0;
    #1;
    chk("t1_ready_exec", 32'(req_ready), 32'd0);
    chk("t1_busy_exec", 32'(busy), 32'd1);
    chk("t1_valid_exec", 32'(rsp_valid), 32'd0);
    chk("t1_alu_b", alu_operand_2, 32'd7);
    tick();
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_result", rsp_result, 32'd12);
    tick();
    chk("t1_valid_hold", 32'(rsp_valid), 32'd1);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;
    #1;
    chk("t1_valid_clr", 32'(rsp_valid), 32'd0);
    chk("t1_busy_done", 32'(busy), 32'd0);

    // Contention from reset with back-to-back issue
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    cnt[0] = 0; cnt[1] = 0; fired = '0; grants = 0; last_cyc = -1; turn = 0;
    load_op(0, 0);
    load_op(1, 0);
    rsp_ready = 2'b11;
    for (int cyc = 0; cyc < 200 && !(grants == 18 && sb.size() == 0); cyc++) begin
      #1;
      if (req_ready !== 2'b00) begin
        chk("t2_grant", 32'(req_ready), (turn == 1) ? 32'd2 : 32'd1);
        if (last_cyc >= 0) chk("t2_gap", 32'(cyc - last_cyc), 32'd2);
        last_cyc = cyc;
        push_exp((turn == 1) ? 2'b10 : 2'b01, exp_res(turn, cnt[turn]));
        fired[turn] = 1'b1;
        turn  = 1 - turn;
        grants++;
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        if (fired[i]) begin
          cnt[i]++;
          if (cnt[i] < 9) load_op(i, cnt[i]);
          else            req_valid[i] = 1'b0;
        end
      end
      fired = '0;
    end
    chk("t2_grants", 32'(grants), 32'd18);
    chk("t2_drained", 32'(sb.size()), 32'd0);
    rsp_ready = '0;

    // Backpressure on requester 1 while requester 0 waits
    tick();
    set_req(1, ALU_ADD, 32'd20, 32'd22);
    push_exp(2'b10, 32'd42);
    #1;
    chk("t3_ready1", 32'(req_ready), 32'd2);
    tick();
    req_valid = '0;
    set_req(0, ALU_SUB, 32'd50, 32'd9);
    #1;
    chk("t3_ready_exec", 32'(req_ready), 32'd0);
    tick();
    chk("t3_valid", 32'(rsp_valid), 32'd2);
    chk("t3_result", rsp_result, 32'd42);
    rsp_ready = 2'b01;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t3_hold_valid", 32'(rsp_valid), 32'd2);
      chk("t3_hold_result", rsp_result, 32'd42);
      chk("t3_hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 2'b10;
    push_exp(2'b01, 32'd41);
    #1;
    chk("t3_grant0", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    rsp_ready = 2'b01;
    #1;
    chk("t3_valid_clr", 32'(rsp_valid), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    tick();
    chk("t3_valid0", 32'(rsp_valid), 32'd1);
    chk("t3_result0", rsp_result, 32'd41);
    tick();
    rsp_ready = '0;
    #1;
    chk("t3_idle", 32'(busy), 32'd0);

    // Signed versus unsigned through the ALU
    do_op("t4_lt",  1, ALU_LT,  32'hFFFF_FFFF, 32'd1, 32'd1);
    do_op("t4_ltu", 0, ALU_LTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    do_op("t4_sra", 1, ALU_SRA, 32'hFFFF_FFFF, 32'd4, 32'hFFFF_FFFF);

    // Asynchronous reset during EXEC drops the operation
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    #1;
    chk("t5_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    #1;
    chk("t5_busy_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_result", rsp_result, 32'd0);
    chk("t5_rst_alu_a", alu_operand_1, 32'd0);
    tick();
    rst_n = 1'b1;
    set_req(0, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
    set_req(1, ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
    push_exp(2'b01, 32'h0000_00FF);
    push_exp(2'b10, 32'h0F00_0F00);
    rsp_ready = 2'b11;
    #1;
    chk("t5_prio0", 32'(req_ready), 32'd1);
    tick();
    req_valid[0] = 1'b0;
    #1;
    chk("t5_ready_exec", 32'(req_ready), 32'd0);
    tick();
    chk("t5_b2b", 32'(req_ready), 32'd2);
    tick();
    req_valid[1] = 1'b0;
    tick();
    chk("t5_valid1", 32'(rsp_valid), 32'd2);
    tick();
    rsp_ready = '0;
    #1;
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_no_stale", 32'(sb.size()), 32'd0);

    // Idle invariance: operands hold, pointer does not move
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_ready", 32'(req_ready), 32'd0);
      chk("t6_alu_a", alu_operand_1, 32'hFF00_FF00);
      chk("t6_alu_b", alu_operand_2, 32'h0FF0_0FF0);
    end
    set_req(0, ALU_ADD, 32'd3, 32'd4);
    set_req(1, ALU_ADD, 32'd8, 32'd9);
    push_exp(2'b01, 32'd7);
    #1;
    chk("t6_ptr", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    tick();
    chk("t6_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;
    #1;
    chk("t6_done", 32'(busy), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational ALU between NUM_REQ requesters (e.g. integer pipe, address-gen unit, branch-compare unit). Requesters present valid/ready requests. A round-robin arbiter grants one request at a time and registers its operation and operands into the ALU. The result is then returned to the winning requester on a per-requester valid/ready response channel. The ALU is instantiated outside this block, which drives its inputs and samples its result.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ID_W, 1, width of grant index; must equal ceil(log2(NUM_REQ)), minimum 1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  request valid per requester
req_ready  out  NUM_REQ  request accepted (one-hot or zero)
req_op  in  5*NUM_REQ  ALU_* opcode per requester, slice [5*i+:5]
req_a  in  32*NUM_REQ  operand_1 per requester, slice [32*i+:32]
req_b  in  32*NUM_REQ  operand_2 per requester, slice [32*i+:32]
rsp_valid  out  NUM_REQ  response valid, one-hot or zero
rsp_ready  in  NUM_REQ  response consumed per requester
rsp_result  out  32  shared result bus, meaningful for the requester whose rsp_valid is high
alu_operation  out  5  to ALU operation
alu_operand_1  out  32  to ALU operand_1
alu_operand_2  out  32  to ALU operand_2
alu_result  in  32  from ALU result (combinational)
busy  out  1  high in EXEC or RESP

Behaviour:
- States: IDLE, EXEC, RESP. Encoding lives in defines.v.
- Reset values: state IDLE; req_ready 0; rsp_valid 0; rsp_result 0; alu_operation/operand regs 0; grant id 0; round-robin pointer NUM_REQ-1, so requester 0 has first priority.
- IDLE, any req_valid high:
  - Pick the winner, searching from pointer+1 upward with wrap.
  - Assert req_ready[winner] combinationally this cycle.
  - At the clock edge, latch op/a/b into the ALU-drive registers, latch the id, set pointer to winner, and go to EXEC.
- IDLE, no req_valid: req_ready all 0 and the block stays in IDLE.
- EXEC (exactly 1 cycle):
  - ALU inputs are driven from the registers.
  - At the edge, rsp_result <= alu_result, rsp_valid[id] <= 1, go to RESP.
- RESP:
  - rsp_valid[id] and rsp_result are held stable until rsp_ready[id].
  - Handshake with no pending req_valid: clear rsp_valid and go to IDLE.
  - Handshake with a pending request: grant it in the same cycle (req_ready asserted, new operands latched) and go directly to EXEC. This is back-to-back issue.
  - No handshake: req_ready is 0.
- Latency: request accept edge to rsp_valid high is 2 cycles. Peak throughput is 1 operation per 2 cycles.
- req_ready is never asserted in EXEC, or in RESP without the response handshake.
- Requests must hold op/a/b stable while valid and not ready.
- A requester may have at most one operation outstanding. Its next request is grantable in the same cycle its response completes.
- rsp_ready on non-owning requesters is ignored.
- Opcodes pass through unchecked. An undefined opcode returns whatever the ALU returns (0).
- ALU inputs hold the last granted values while IDLE; no toggling to zero.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ grants.
- Async reset in EXEC or RESP drops the in-flight operation. No response is produced, and all outputs return to their reset values immediately.
- The pointer is updated only on a grant, never on an idle cycle.

Decomposition:
- defines.v (shared): ARB_IDLE/ARB_EXEC/ARB_RESP 2-bit state constants, next to the existing ALU_* opcodes.
- Sub-module rr_pick: purely combinational. Inputs: NUM_REQ request vector and pointer. Outputs: one-hot grant and encoded index.
- alu_arbiter holds the FSM, the operand/result registers and the pointer.

Test Plan:
1. Single request: req 0, ALU_ADD, a=5, b=7 -> req_ready[0] for 1 cycle; 2 cycles later rsp_valid[0]=1, rsp_result=12; rsp_ready[0]=1 -> IDLE.
2. Contention: req 0 and req 1 valid from reset with ALU_SUB 10-3 and ALU_SLL 1<<4, rsp_ready tied high -> req 0 granted first (result 7), req 1 granted back-to-back at the response handshake (result 16). Grants alternate over 8 further requests each.
3. Backpressure: hold rsp_ready[1]=0 for 5 cycles with req 0 pending -> rsp_valid[1] and rsp_result stable, req_ready[0]=0 throughout. Req 0 is granted in the cycle rsp_ready[1] rises.
4. Signed/unsigned check via the ALU: a=32'hFFFFFFFF, b=1 -> ALU_LT gives 1, ALU_LTU gives 0, ALU_SRA by 4 gives 32'hFFFFFFFF.
5. Reset mid-op: deassert rst_n in EXEC -> rsp_valid, req_ready and busy go 0 asynchronously. After release, requester 0 has priority and no stale response appears.
6. Idle invariance: 20 cycles with no req_valid -> pointer unchanged, busy=0, alu_operand_* hold the last granted values.
